pwm_quad_mc: RTL and testbench
==============================

Name: pwm_quad_mc

Overview:
- Multi-channel PWM generator and x4 quadrature-encoder counter, one channel per motor axis.
- Sits as an Avalon-MM slave peripheral in the Nios system. Per-channel PWM outputs and encoder inputs go to GPIO.
- Generalises the current single PWM-out / encoder-in pair with:
  - N channels;
  - parametrised counter widths;
  - glitch-free shadowed duty/period updates;
  - output polarity control;
  - encoder error detection.

Parameters:
- NUM_CH, 2: number of channels (1..8).
- PWM_W, 16: PWM period/duty counter width (2..32).
- POS_W, 32: encoder position width (8..32). Read value is sign-extended to 32 bits.
- SYNC_STAGES, 2: synchroniser depth on encoder inputs (2..4).

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- address  in  $clog2(NUM_CH)+2  word address = {channel, reg[1:0]}.
- write  in  1  write strobe.
- writedata  in  32  write data.
- read  in  1  read strobe.
- readdata  out  32  read data, valid the cycle after read (fixed latency 1).
- pwm_out  out  NUM_CH  PWM outputs.
- enc_a  in  NUM_CH  encoder A phase (asynchronous).
- enc_b  in  NUM_CH  encoder B phase (asynchronous).

Behaviour:
- Register map per channel, by reg index:
  - 0 PERIOD (RW, low PWM_W bits).
  - 1 DUTY (RW, low PWM_W bits).
  - 2 CTRL/STATUS:
    - bit0 enable (RW);
    - bit1 invert (RW);
    - bit8 enc_err (RO, sticky, write-1-to-clear).
  - 3 POSITION (read: sign-extended count; write: load value).
  - Channel fields beyond NUM_CH read 0; writes to them are ignored.
- Reset: every register, shadow, counter and position = 0; sync flops = 0; readdata = 0; pwm_out = 0.
- PWM counter:
  - Counts 0..per_act-1, then wraps to 0.
  - per_act and duty_act are shadow copies, loaded from PERIOD/DUTY only at wrap, or while disabled.
  - Register writes never glitch the current period.
- Raw PWM level = (cnt < duty_act).
  - duty_act >= per_act gives 100%.
  - duty_act = 0 gives 0%.
  - per_act = 0: counter holds at 0, raw level = 0.
- pwm_out = raw level XOR invert, registered (1 cycle after counter).
- Disabled (enable = 0):
  - Counter held at 0, shadows track the registers every cycle.
  - pwm_out = invert.
- Enable 0->1: first period starts with cnt = 0 on the next cycle, using the current PERIOD/DUTY.
- Encoder path:
  - enc_a/enc_b pass through SYNC_STAGES flops; previous synced {a,b} is kept.
  - Gray transitions 00->01->11->10->00 = +1; reverse direction = -1.
  - No change = 0.
  - Both bits changing = no count, set enc_err.
- Position wraps modulo 2^POS_W (0 - 1 = all ones).
- A POSITION write in the same cycle as an encoder step: the write wins and the step is dropped.
- enc_err set and W1C in the same cycle: set wins.
- Reads have no side effects. readdata holds its value when read = 0.
- Mid-operation reset: all state returns to reset values immediately (async). pwm_out = 0 regardless of invert.

Decomposition:
- Package pwm_quad_pkg:
  - register index constants REG_PERIOD=0, REG_DUTY=1, REG_CTRL=2, REG_POS=3;
  - CTRL bit positions;
  - typedef for the 2-bit quadrature state;
  - function quad_step(prev, cur) returning +1 / -1 / 0 / err.
- One sub-module pwm_quad_ch (a single channel: registers, shadows, PWM counter, synchroniser, position counter).
- The top instantiates NUM_CH copies with a generate loop and holds the address decode and readdata mux.

Test Plan:
- PERIOD=10, DUTY=3, enable=1, invert=0 -> pwm_out high 3 clks, low 7 clks, repeating. First rising edge 2 clks after the CTRL write.
- Mid-period write DUTY=7 while cnt=5 -> current period keeps 3-high. Next period is 7-high/3-low. No extra edges.
- DUTY=0 -> constant 0. DUTY=12 with PERIOD=10 -> constant 1. PERIOD=0 -> constant 0. invert=1 with enable=0 -> pwm_out=1.
- Encoder sequence 00,01,11,10,00 on ch1 (each held 4 clks) -> POSITION=4. Reverse sequence 5 steps -> POSITION=0xFFFFFFFF (POS_W=32). enc_err=0.
- Encoder jump 00->11 -> position unchanged, STATUS bit8=1. Write 0x100 to CTRL -> bit8=0. POSITION write of 100 coincident with a +1 step -> reads 100.
- NUM_CH=4, PWM_W=8 instance: independent PERIOD values 4/5/6/7 on the four channels -> each output's period is correct. Assert reset mid-run -> all pwm_out=0, all POSITION=0 immediately.

Source files
------------

// File: rtl/pwm_quad_pkg.sv
// Shared constants, types and quadrature decode helper for the PWM / encoder block.
package pwm_quad_pkg;

    localparam logic [1:0] REG_PERIOD = 2'd0;
    localparam logic [1:0] REG_DUTY   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_POS    = 2'd3;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_INV_BIT = 1;
    localparam int unsigned CTRL_ERR_BIT = 8;

    // Synchronised encoder state as {a, b}
    typedef logic [1:0] quad_t;

    typedef enum logic [1:0] {
        QuadNone,
        QuadInc,
        QuadDec,
        QuadErr
    } quad_step_e;

    // Position of a state around the cycle 00 -> 01 -> 11 -> 10
    function automatic logic [1:0] gray_idx(input quad_t s);
        return {s[1], s[1] ^ s[0]};
    endfunction

    function automatic quad_step_e quad_step(input quad_t prev, input quad_t cur);
        logic [1:0] diff;
        diff = gray_idx(cur) - gray_idx(prev);
        case (diff)
            2'd0:    return QuadNone;
            2'd1:    return QuadInc;
            2'd3:    return QuadDec;
            default: return QuadErr;
        endcase
    endfunction

endpackage

// File: rtl/pwm_quad_mc_if.sv
// Avalon-MM style register bus with fixed read latency of one cycle.
interface pwm_quad_mc_if #(
    parameter int unsigned AW = 3
) ();

    logic [AW-1:0] address;
    logic          write;
    logic [31:0]   writedata;
    logic          read;
    logic [31:0]   readdata;

    modport master (
        output address,
        output write,
        output writedata,
        output read,
        input  readdata
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  read,
        output readdata
    );

endinterface

// File: rtl/pwm_quad_ch.sv
// One motor axis: register file, shadowed PWM generator and x4 quadrature position counter.
module pwm_quad_ch
    import pwm_quad_pkg::*;
#(
    parameter int unsigned PWM_W       = 16,
    parameter int unsigned POS_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en_i,
    input  logic [1:0]  reg_idx_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        pwm_o,
    input  logic        enc_a_i,
    input  logic        enc_b_i
);

    localparam logic [PWM_W-1:0] PwmOne = 1;
    localparam logic [POS_W-1:0] PosOne = 1;

    logic [PWM_W-1:0] per_q, per_d, duty_q, duty_d;
    logic             en_q, en_d, inv_q, inv_d, err_q, err_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [PWM_W-1:0] cnt_q, cnt_d, per_act_q, per_act_d, duty_act_q, duty_act_d;
    logic             pwm_q, pwm_d;
    logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d, sync_b_q, sync_b_d;
    quad_t            prev_q, prev_d, cur;
    quad_step_e       step;
    logic             pos_wr, err_clr, raw;
    logic signed [POS_W-1:0] pos_s;

    always_comb begin
        per_d  = per_q;
        duty_d = duty_q;
        en_d   = en_q;
        inv_d  = inv_q;
        if (wr_en_i) begin
            case (reg_idx_i)
                REG_PERIOD: per_d = wdata_i[PWM_W-1:0];
                REG_DUTY:   duty_d = wdata_i[PWM_W-1:0];
                REG_CTRL: begin
                    en_d  = wdata_i[CTRL_EN_BIT];
                    inv_d = wdata_i[CTRL_INV_BIT];
                end
                default: ;
            endcase
        end
    end

    // Shadows reload only at wrap (or every cycle while idle) so writes never cut a period short.
    always_comb begin
        cnt_d      = cnt_q;
        per_act_d  = per_act_q;
        duty_act_d = duty_act_q;
        if (!en_q || per_act_q == '0 || cnt_q == per_act_q - PwmOne) begin
            cnt_d      = '0;
            per_act_d  = per_q;
            duty_act_d = duty_q;
        end else begin
            cnt_d = cnt_q + PwmOne;
        end
    end

    assign raw   = (per_act_q != '0) && (cnt_q < duty_act_q);
    assign pwm_d = en_q ? (raw ^ inv_q) : inv_q;
    assign pwm_o = pwm_q;

    assign sync_a_d = {sync_a_q[SYNC_STAGES-2:0], enc_a_i};
    assign sync_b_d = {sync_b_q[SYNC_STAGES-2:0], enc_b_i};
    assign cur      = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
    assign prev_d   = cur;
    assign step     = quad_step(prev_q, cur);
    assign pos_wr   = wr_en_i && (reg_idx_i == REG_POS);
    assign err_clr  = wr_en_i && (reg_idx_i == REG_CTRL) && wdata_i[CTRL_ERR_BIT];

    // A bus load overrides any coincident encoder step; a new error beats a clear.
    always_comb begin
        pos_d = pos_q;
        if (pos_wr) begin
            pos_d = wdata_i[POS_W-1:0];
        end else if (step == QuadInc) begin
            pos_d = pos_q + PosOne;
        end else if (step == QuadDec) begin
            pos_d = pos_q - PosOne;
        end
        if (step == QuadErr) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign pos_s = pos_q;

    always_comb begin
        rdata_o = '0;
        case (reg_idx_i)
            REG_PERIOD: rdata_o = 32'(per_q);
            REG_DUTY:   rdata_o = 32'(duty_q);
            REG_CTRL: begin
                rdata_o[CTRL_EN_BIT]  = en_q;
                rdata_o[CTRL_INV_BIT] = inv_q;
                rdata_o[CTRL_ERR_BIT] = err_q;
            end
            default:    rdata_o = 32'(pos_s);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_q      <= '0;
            duty_q     <= '0;
            en_q       <= 1'b0;
            inv_q      <= 1'b0;
            err_q      <= 1'b0;
            pos_q      <= '0;
            cnt_q      <= '0;
            per_act_q  <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
            sync_a_q   <= '0;
            sync_b_q   <= '0;
            prev_q     <= '0;
        end else begin
            per_q      <= per_d;
            duty_q     <= duty_d;
            en_q       <= en_d;
            inv_q      <= inv_d;
            err_q      <= err_d;
            pos_q      <= pos_d;
            cnt_q      <= cnt_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
            sync_a_q   <= sync_a_d;
            sync_b_q   <= sync_b_d;
            prev_q     <= prev_d;
        end
    end

endmodule

// File: rtl/pwm_quad_mc.sv
// Multi-channel PWM + quadrature encoder peripheral: address decode and registered read mux.
module pwm_quad_mc
    import pwm_quad_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned PWM_W       = 16,
    parameter int unsigned POS_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    pwm_quad_mc_if.slave      bus,
    output logic [NUM_CH-1:0] pwm_out,
    input  logic [NUM_CH-1:0] enc_a,
    input  logic [NUM_CH-1:0] enc_b
);

    logic [31:0] ch_idx;
    logic [1:0]  reg_idx;
    logic [31:0] ch_rdata [NUM_CH];
    logic [31:0] sel_rdata;
    logic [31:0] readdata_q, readdata_d;

    // Widening first keeps a zero-width channel field (NUM_CH = 1) well defined
    assign ch_idx  = 32'(bus.address) >> 2;
    assign reg_idx = bus.address[1:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_quad_ch #(
            .PWM_W      (PWM_W),
            .POS_W      (POS_W),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .wr_en_i  (bus.write && (ch_idx == 32'(i))),
            .reg_idx_i(reg_idx),
            .wdata_i  (bus.writedata),
            .rdata_o  (ch_rdata[i]),
            .pwm_o    (pwm_out[i]),
            .enc_a_i  (enc_a[i]),
            .enc_b_i  (enc_b[i])
        );
    end

    always_comb begin
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_idx == i) begin
                sel_rdata = ch_rdata[i];
            end
        end
        readdata_d = bus.read ? sel_rdata : readdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_pwm_quad_mc.sv
// Bench for pwm_quad_mc: PWM vector table, random PWM/encoder runs vs a model, 4-channel instance.
module tb_pwm_quad_mc;

    logic clk = 1'b0;
    logic rst0, rst4;
    always #5 clk = ~clk;

    pwm_quad_mc_if #(.AW(3)) bus0 ();
    pwm_quad_mc_if #(.AW(4)) bus4 ();

    logic [1:0] pwm0, ea0, eb0;
    logic [3:0] pwm4, ea4, eb4;

    pwm_quad_mc #(.NUM_CH(2)) dut (
        .clk(clk), .reset(rst0), .bus(bus0), .pwm_out(pwm0), .enc_a(ea0), .enc_b(eb0)
    );

    pwm_quad_mc #(.NUM_CH(4), .PWM_W(8)) dut4 (
        .clk(clk), .reset(rst4), .bus(bus4), .pwm_out(pwm4), .enc_a(ea4), .enc_b(eb4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int per;
        int duty;
        bit inv;
        bit en;
        int len;
        int hi;
    } pvec_t;

    pvec_t tv[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input bit u4, input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        if (u4) begin
            bus4.address = addr; bus4.writedata = data; bus4.write = 1'b1;
        end else begin
            bus0.address = addr[2:0]; bus0.writedata = data; bus0.write = 1'b1;
        end
        @(negedge clk);
        bus0.write = 1'b0;
        bus4.write = 1'b0;
    endtask

    task automatic rd(input bit u4, input logic [3:0] addr, output logic [31:0] data);
        @(negedge clk);
        if (u4) begin
            bus4.address = addr; bus4.read = 1'b1;
        end else begin
            bus0.address = addr[2:0]; bus0.read = 1'b1;
        end
        @(negedge clk);
        bus0.read = 1'b0;
        bus4.read = 1'b0;
        data = u4 ? bus4.readdata : bus0.readdata;
    endtask

    // Waveform expected from the spec: sample k shows counter value k of the first period
    function automatic logic [63:0] pwm_ref(input int n, input int len, input int hi, input bit inv);
        logic [63:0] e = '0;
        for (int k = 0; k < n; k++) e[k] = inv ^ ((k % len) < hi);
        return e;
    endfunction

    task automatic cap0(input int n, output logic [63:0] w);
        w = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            w[k] = pwm0[0];
        end
    endtask

    task automatic run_pwm(input string name, input int per, input int duty, input bit inv,
                           input bit en, input int len, input int hi);
        logic [63:0] w;
        wr(0, 4'd2, 32'h0);
        wr(0, 4'd0, 32'(per));
        wr(0, 4'd1, 32'(duty));
        wr(0, 4'd2, {30'd0, inv, en});
        check({name, "_pre"}, 64'(pwm0[0]), 64'd0);
        cap0(40, w);
        check(name, w[39:0], pwm_ref(40, len, hi, inv));
    endtask

    task automatic enc0(input int ch, input logic [1:0] st, input int hold);
        @(negedge clk);
        ea0[ch] = st[1];
        eb0[ch] = st[0];
        repeat (hold - 1) @(negedge clk);
    endtask

    int gidx[4] = '{0, 1, 3, 2};  // cycle position of state {a,b}; also state at a position

    initial begin
        logic [31:0] d, d2;
        logic [63:0] w;
        logic [63:0] w4[4];
        logic [31:0] mpos;
        bit merr;
        logic [1:0] st, nx;
        int r, found;

        rst0 = 1'b1; rst4 = 1'b1;
        ea0 = '0; eb0 = '0; ea4 = '0; eb4 = '0;
        bus0.address = '0; bus0.write = 0; bus0.writedata = '0; bus0.read = 0;
        bus4.address = '0; bus4.write = 0; bus4.writedata = '0; bus4.read = 0;
        #1;
        check("reset_pwm", 64'(pwm0), 64'd0);
        check("reset_rdata", 64'(bus0.readdata), 64'd0);
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst4 = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(0, 4'(a), d);
            check($sformatf("reset_reg%0d", a), 64'(d), 64'd0);
        end

        // PWM vector table
        tv[0] = '{10, 3, 1'b0, 1'b1, 10, 3};
        tv[1] = '{10, 0, 1'b0, 1'b1, 1, 0};
        tv[2] = '{10, 12, 1'b0, 1'b1, 1, 1};
        tv[3] = '{0, 5, 1'b0, 1'b1, 1, 0};
        tv[4] = '{10, 3, 1'b1, 1'b0, 1, 0};
        tv[5] = '{8, 5, 1'b1, 1'b1, 8, 5};
        tv[6] = '{1, 1, 1'b0, 1'b1, 1, 1};
        for (int i = 0; i < 7; i++) begin
            run_pwm($sformatf("pwm_vec%0d", i), tv[i].per, tv[i].duty, tv[i].inv, tv[i].en,
                    tv[i].len, tv[i].hi);
        end

        rd(0, 4'd0, d);
        check("rd_period", 64'(d), 64'd1);
        repeat (2) @(negedge clk);
        check("rd_hold", 64'(bus0.readdata), 64'd1);

        // DUTY rewritten mid-period takes effect only from the next period
        wr(0, 4'd2, 32'h0);
        wr(0, 4'd0, 32'd10);
        wr(0, 4'd1, 32'd3);
        wr(0, 4'd2, 32'h1);
        w = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            w[k] = pwm0[0];
            if (k == 4) begin
                bus0.address = 3'd1; bus0.writedata = 32'd7; bus0.write = 1'b1;
            end else begin
                bus0.write = 1'b0;
            end
        end
        d2 = 0;
        check("pwm_midwrite", w[39:0], {pwm_ref(40, 10, 7, 0)} & ~64'h3FF | pwm_ref(10, 10, 3, 0));

        // Random PWM settings vs model
        for (int i = 0; i < 6; i++) begin
            int per, duty;
            bit inv;
            per  = $urandom_range(1, 12);
            duty = $urandom_range(0, 14);
            inv  = 1'($urandom_range(0, 1));
            run_pwm($sformatf("pwm_rand%0d_p%0d_d%0d", i, per, duty), per, duty, inv, 1'b1, per,
                    duty);
        end

        // Directed encoder sequences on channel 1
        enc0(1, 2'b01, 4); enc0(1, 2'b11, 4); enc0(1, 2'b10, 4); enc0(1, 2'b00, 4);
        repeat (4) @(negedge clk);
        rd(0, 4'd7, d);
        check("enc_fwd4", 64'(d), 64'd4);
        enc0(1, 2'b10, 4); enc0(1, 2'b11, 4); enc0(1, 2'b01, 4); enc0(1, 2'b00, 4);
        enc0(1, 2'b10, 4);
        repeat (4) @(negedge clk);
        rd(0, 4'd7, d);
        check("enc_rev5", 64'(d), 64'hFFFF_FFFF);
        rd(0, 4'd6, d);
        check("enc_noerr", 64'(d), 64'd0);
        enc0(1, 2'b00, 4);
        enc0(1, 2'b11, 4);
        repeat (4) @(negedge clk);
        rd(0, 4'd7, d);
        check("enc_jump_pos", 64'(d), 64'd0);
        rd(0, 4'd6, d);
        check("enc_jump_err", 64'(d), 64'h100);
        wr(0, 4'd6, 32'h100);
        rd(0, 4'd6, d);
        check("enc_w1c", 64'(d), 64'd0);
        // Load lands on the same edge as the +1 step from 11 -> 10
        @(negedge clk);
        ea0[1] = 1'b1; eb0[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus0.address = 3'd7; bus0.writedata = 32'd100; bus0.write = 1'b1;
        @(negedge clk);
        bus0.write = 1'b0;
        repeat (4) @(negedge clk);
        rd(0, 4'd7, d);
        check("enc_load_wins", 64'(d), 64'd100);

        // Random encoder walk on channel 0 vs model
        mpos = 0; merr = 0; st = 2'b00;
        for (int rnd = 0; rnd < 6; rnd++) begin
            for (int m = 0; m < 20; m++) begin
                int c, dlt;
                c = $urandom_range(0, 9);
                dlt = (c < 4) ? 1 : (c < 8) ? 3 : (c < 9) ? 0 : 2;
                nx = 2'(gidx[(gidx[st] + dlt) % 4]);
                if (dlt == 1) mpos = mpos + 1;
                if (dlt == 3) mpos = mpos - 1;
                if (dlt == 2) merr = 1;
                enc0(0, nx, $urandom_range(1, 4));
                st = nx;
            end
            repeat (4) @(negedge clk);
            rd(0, 4'd3, d);
            check($sformatf("enc_rand%0d_pos", rnd), 64'(d), 64'(mpos));
            rd(0, 4'd2, d);
            check($sformatf("enc_rand%0d_err", rnd), 64'(d[8]), 64'(merr));
            wr(0, 4'd2, 32'h100);
            merr = 0;
        end

        // Four-channel instance: independent periods 4..7, duty 2
        for (int c = 0; c < 4; c++) begin
            wr(1, 4'(c * 4), 32'(c + 4));
            wr(1, 4'(c * 4 + 1), 32'd2);
            wr(1, 4'(c * 4 + 2), 32'h1);
        end
        for (int c = 0; c < 4; c++) w4[c] = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) w4[c][k] = pwm4[c];
        end
        for (int c = 0; c < 4; c++) begin
            found = 0; r = 0;
            for (int k = 1; k < c + 6; k++) begin
                if (!found && w4[c][k] && !w4[c][k-1]) begin
                    found = 1; r = k;
                end
            end
            w = w4[c] >> r;
            check($sformatf("ch4_rise%0d", c), 64'(found), 64'd1);
            check($sformatf("ch4_period%0d", c), 64'(w[27:0]), pwm_ref(28, c + 4, 2, 0));
        end

        // Encoder steps on ch2, invert on ch3, then asynchronous reset mid-run
        @(negedge clk); ea4[2] = 0; eb4[2] = 1; repeat (3) @(negedge clk);
        ea4[2] = 1; eb4[2] = 1; repeat (3) @(negedge clk);
        ea4[2] = 1; eb4[2] = 0; repeat (4) @(negedge clk);
        rd(1, 4'd11, d);
        check("ch4_pos_pre", 64'(d), 64'd3);
        wr(1, 4'd14, 32'h3);
        repeat (3) @(negedge clk);
        #2 rst4 = 1'b1;
        #1;
        check("rst_mid_pwm", 64'(pwm4), 64'd0);
        check("rst_mid_rdata", 64'(bus4.readdata), 64'd0);
        ea4 = '0; eb4 = '0;
        @(negedge clk);
        rst4 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            rd(1, 4'(c * 4 + 3), d);
            check($sformatf("rst_pos%0d", c), 64'(d), 64'd0);
        end
        repeat (3) @(negedge clk);
        check("rst_after_pwm", 64'(pwm4), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
